// File: rtl/sprite_path_mover.sv
// rtl/sprite_path_mover.sv - diagonal sprite stepper with walkway-band validation and drawer sequencing
// Steps once per rate tick, validates against seg_table and a teleport pad, then erases and redraws.
module sprite_path_mover #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int STEP     = 1,
  parameter int X_MAX    = 319,
  parameter int Y_MAX    = 239,
  parameter int RATE_DIV = 6250000,
  parameter int NUM_SEG  = 8,
  parameter int START_X  = 95,
  parameter int START_Y  = 221,
  parameter int TP_EN    = 1,
  parameter int TP_SRC_X = 120,
  parameter int TP_SRC_Y = 196,
  parameter int TP_DST_X = 126,
  parameter int TP_DST_Y = 68,
  localparam int C_W     = X_W + 1,
  localparam int SEG_W   = 1 + 2*C_W + 2*X_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     move,
  input  logic [1:0]               dir,
  input  logic [NUM_SEG*SEG_W-1:0] seg_table,
  input  logic                     doneBG,
  input  logic                     doneChar,
  output logic [X_W-1:0]           xCoordinate,
  output logic [Y_W-1:0]           yCoordinate,
  output logic                     drawBG,
  output logic                     drawChar,
  output logic                     busy,
  output logic                     blocked
);
  localparam int N_W   = C_W + 1;
  localparam int CNT_W = $clog2(RATE_DIV);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ERASE, S_UPDATE, S_DRAW} state_t;

  state_t           state;
  logic [1:0]       dir_q;
  logic             tp_q;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_W'(RATE_DIV - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Candidate is one bit wider than the key and signed so a step below 1 shows as negative.
  logic signed [N_W-1:0] cur_x, cur_y, step_s, new_x, new_y;
  assign cur_x  = $signed({{(N_W-X_W){1'b0}}, xCoordinate});
  assign cur_y  = $signed({{(N_W-Y_W){1'b0}}, yCoordinate});
  assign step_s = $signed(N_W'(STEP));
  assign new_x  = dir_q[0] ? cur_x - step_s : cur_x + step_s;
  assign new_y  = dir_q[1] ? cur_y - step_s : cur_y + step_s;

  logic in_bounds, tp_hit, seg_hit, valid;
  assign in_bounds = (new_x >= $signed(N_W'(1))) && (new_x <= $signed(N_W'(X_MAX))) &&
                     (new_y >= $signed(N_W'(1))) && (new_y <= $signed(N_W'(Y_MAX)));
  assign tp_hit    = (TP_EN != 0) && (new_x == $signed(N_W'(TP_SRC_X))) &&
                     (new_y == $signed(N_W'(TP_SRC_Y)));
  assign valid     = in_bounds && (tp_hit || seg_hit);

  logic [C_W-1:0]   key_x, key_y, key, c_lo, c_hi;
  logic [X_W-1:0]   x_min, x_max;
  logic [SEG_W-1:0] seg;
  assign key_x = new_x[C_W-1:0];
  assign key_y = new_y[C_W-1:0];

  // type 1 bands run the other diagonal, so the key is x - y offset by 2^Y_W to stay positive
  always_comb begin
    seg_hit = 1'b0;
    seg     = '0;
    c_lo    = '0;
    c_hi    = '0;
    x_min   = '0;
    x_max   = '0;
    key     = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      seg   = seg_table[i*SEG_W +: SEG_W];
      c_lo  = seg[SEG_W-2 -: C_W];
      c_hi  = seg[SEG_W-2-C_W -: C_W];
      x_min = seg[2*X_W-1 -: X_W];
      x_max = seg[X_W-1:0];
      key   = seg[SEG_W-1] ? key_x + C_W'(2**Y_W) - key_y : key_x + key_y;
      if (({1'b0, x_min} <= key_x) && (key_x <= {1'b0, x_max}) && (c_lo <= key) && (key <= c_hi))
        seg_hit = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      dir_q       <= 2'd0;
      tp_q        <= 1'b0;
      xCoordinate <= X_W'(START_X);
      yCoordinate <= Y_W'(START_Y);
      drawBG      <= 1'b0;
      drawChar    <= 1'b0;
      busy        <= 1'b0;
      blocked     <= 1'b0;
    end else begin
      blocked <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && move) begin
            dir_q <= dir;
            busy  <= 1'b1;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (valid) begin
            tp_q   <= tp_hit;
            drawBG <= 1'b1;
            state  <= S_ERASE;
          end else begin
            blocked <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        S_ERASE: begin
          if (doneBG) begin
            drawBG <= 1'b0;
            state  <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          xCoordinate <= tp_q ? X_W'(TP_DST_X) : new_x[X_W-1:0];
          yCoordinate <= tp_q ? Y_W'(TP_DST_Y) : new_y[Y_W-1:0];
          tp_q        <= 1'b0;
          drawChar    <= 1'b1;
          state       <= S_DRAW;
        end
        S_DRAW: begin
          if (doneChar) begin
            drawChar <= 1'b0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_path_mover.sv
// tb/tb_sprite_path_mover.sv - table-driven bench for sprite_path_mover
// Four instances cover default start, left-edge start, teleport enabled and teleport disabled.
module tb_sprite_path_mover;
  localparam int SEG_W = 39;
  localparam int TBL_W = 8 * SEG_W;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             move = 1'b0;
  logic [1:0]       dir = 2'd0;
  logic [TBL_W-1:0] seg_table = '0;
  logic             doneBG = 1'b0;
  logic             doneChar = 1'b0;

  logic [8:0] xo [4];
  logic [7:0] yo [4];
  logic       bgo [4];
  logic       cho [4];
  logic       byo [4];
  logic       blo [4];

  int checks = 0;
  int failures = 0;
  int bg_rises = 0;
  logic bg_prev = 1'b0;

  always #5 clock = ~clock;

  sprite_path_mover #(.RATE_DIV(4)) dut0 (
    .clock(clock), .reset(reset), .move(move), .dir(dir), .seg_table(seg_table),
    .doneBG(doneBG), .doneChar(doneChar), .xCoordinate(xo[0]), .yCoordinate(yo[0]),
    .drawBG(bgo[0]), .drawChar(cho[0]), .busy(byo[0]), .blocked(blo[0]));
  sprite_path_mover #(.RATE_DIV(4), .START_X(1)) dut1 (
    .clock(clock), .reset(reset), .move(move), .dir(dir), .seg_table(seg_table),
    .doneBG(doneBG), .doneChar(doneChar), .xCoordinate(xo[1]), .yCoordinate(yo[1]),
    .drawBG(bgo[1]), .drawChar(cho[1]), .busy(byo[1]), .blocked(blo[1]));
  sprite_path_mover #(.RATE_DIV(4), .START_X(119), .START_Y(195)) dut2 (
    .clock(clock), .reset(reset), .move(move), .dir(dir), .seg_table(seg_table),
    .doneBG(doneBG), .doneChar(doneChar), .xCoordinate(xo[2]), .yCoordinate(yo[2]),
    .drawBG(bgo[2]), .drawChar(cho[2]), .busy(byo[2]), .blocked(blo[2]));
  sprite_path_mover #(.RATE_DIV(4), .START_X(119), .START_Y(195), .TP_EN(0)) dut3 (
    .clock(clock), .reset(reset), .move(move), .dir(dir), .seg_table(seg_table),
    .doneBG(doneBG), .doneChar(doneChar), .xCoordinate(xo[3]), .yCoordinate(yo[3]),
    .drawBG(bgo[3]), .drawChar(cho[3]), .busy(byo[3]), .blocked(blo[3]));

  typedef struct {
    int               inst;
    logic [1:0]       dir;
    logic [TBL_W-1:0] tbl;
    int               ex;
    int               ey;
    bit               blk;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [SEG_W-1:0] seg(input int t, input int clo, input int chi,
                                           input int xmin, input int xmax);
    return {t[0], clo[9:0], chi[9:0], xmin[8:0], xmax[8:0]};
  endfunction

  function automatic logic [TBL_W-1:0] tbl_at(input int slot, input logic [SEG_W-1:0] s);
    logic [TBL_W-1:0] t;
    t = '0;
    t[slot*SEG_W +: SEG_W] = s;
    return t;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step1();
    @(negedge clock);
    if (bgo[0] && !bg_prev) bg_rises++;
    bg_prev = bgo[0];
  endtask

  task automatic start_run(input logic [1:0] d, input logic [TBL_W-1:0] t, input logic dbg, input logic dch);
    @(negedge clock);
    reset = 1'b1; move = 1'b0; dir = d; seg_table = t; doneBG = dbg; doneChar = dch;
    @(negedge clock);
    reset = 1'b0; move = 1'b1;
    bg_rises = 0; bg_prev = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int bgcnt, chcnt, nblk, nbg, bad, idle_cnt;
    bit busy_seen, fin;
    v = vecs[vi];
    bgcnt = 0; chcnt = 0; nblk = 0; nbg = 0; bad = 0; idle_cnt = 0;
    busy_seen = 0; fin = 0;
    start_run(v.dir, v.tbl, 1'b0, 1'b0);
    for (int c = 0; c < 80 && !fin; c++) begin
      @(negedge clock);
      if (blo[v.inst]) nblk++;
      if (bgo[v.inst]) nbg++;
      if (cho[v.inst] && nbg == 0) bad++;
      if (cho[v.inst] && bgo[v.inst]) bad++;
      if (byo[v.inst]) begin
        busy_seen = 1; move = 1'b0;
      end else if (busy_seen) begin
        idle_cnt++;
      end
      if (idle_cnt >= 3) fin = 1;
      bgcnt = bgo[v.inst] ? bgcnt + 1 : 0;
      chcnt = cho[v.inst] ? chcnt + 1 : 0;
      doneBG = (bgcnt >= 3);
      doneChar = (chcnt >= 3);
    end
    doneBG = 1'b0; doneChar = 1'b0; move = 1'b0;
    chk($sformatf("v%0d_finished", vi), int'(fin), 1);
    chk($sformatf("v%0d_x", vi), int'(xo[v.inst]), v.ex);
    chk($sformatf("v%0d_y", vi), int'(yo[v.inst]), v.ey);
    chk($sformatf("v%0d_blocked_cycles", vi), nblk, v.blk ? 1 : 0);
    chk($sformatf("v%0d_drawBG_seen", vi), int'(nbg > 0), v.blk ? 0 : 1);
    chk($sformatf("v%0d_order_overlap", vi), bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TBL_W-1:0] tA, tE, tF, tG, tH, tW, tZ;
    int first_bg, first_xy, first_idle, waited;

    tA = tbl_at(0, seg(0, 310, 320, 95, 224));
    tE = tbl_at(7, seg(1, 130, 135, 0, 319));
    tF = tbl_at(7, seg(1, 133, 135, 0, 319));
    tG = tbl_at(3, seg(0, 316, 316, 96, 96));
    tH = tbl_at(3, seg(0, 317, 400, 96, 96));
    tW = tbl_at(0, seg(0, 0, 1023, 0, 511));
    tZ = '0;

    vecs.push_back('{0, 2'd2, tA,  96, 220, 1'b0});
    vecs.push_back('{0, 2'd1, tA,  95, 221, 1'b1});
    vecs.push_back('{0, 2'd0, tA,  96, 222, 1'b0});
    vecs.push_back('{0, 2'd3, tA,  95, 221, 1'b1});
    vecs.push_back('{0, 2'd2, tE,  96, 220, 1'b0});
    vecs.push_back('{0, 2'd2, tF,  95, 221, 1'b1});
    vecs.push_back('{0, 2'd2, tG,  96, 220, 1'b0});
    vecs.push_back('{0, 2'd2, tH,  95, 221, 1'b1});
    vecs.push_back('{0, 2'd2, tZ,  95, 221, 1'b1});
    vecs.push_back('{1, 2'd3, tW,   1, 221, 1'b1});
    vecs.push_back('{1, 2'd1, tW,   1, 221, 1'b1});
    vecs.push_back('{1, 2'd2, tW,   2, 220, 1'b0});
    vecs.push_back('{2, 2'd0, tW, 126,  68, 1'b0});
    vecs.push_back('{2, 2'd0, tZ, 126,  68, 1'b0});
    vecs.push_back('{2, 2'd3, tW, 118, 194, 1'b0});
    vecs.push_back('{3, 2'd0, tW, 120, 196, 1'b0});
    vecs.push_back('{3, 2'd0, tZ, 119, 195, 1'b1});

    repeat (2) @(negedge clock);
    chk("reset_x", int'(xo[0]), 95);
    chk("reset_y", int'(yo[0]), 221);
    chk("reset_drawBG", int'(bgo[0]), 0);
    chk("reset_drawChar", int'(cho[0]), 0);
    chk("reset_busy", int'(byo[0]), 0);
    chk("reset_blocked", int'(blo[0]), 0);

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Latency with both done inputs held high: drawBG at sample 5, new coords at 7, idle at 8.
    start_run(2'd2, tA, 1'b1, 1'b1);
    first_bg = -1; first_xy = -1; first_idle = -1;
    for (int i = 1; i <= 12; i++) begin
      step1();
      if (i == 5) move = 1'b0;
      if (bgo[0] && first_bg < 0) first_bg = i;
      if (xo[0] == 9'd96 && yo[0] == 8'd220 && first_xy < 0) first_xy = i;
      if (first_xy > 0 && !byo[0] && first_idle < 0) first_idle = i;
    end
    chk("lat_drawBG", first_bg, 5);
    chk("lat_coords", first_xy, 7);
    chk("lat_idle", first_idle, 8);
    chk("lat_single_erase", bg_rises, 1);

    // Reset mid-erase drops drawBG without a clock edge.
    start_run(2'd2, tA, 1'b0, 1'b0);
    waited = 0;
    while (!bgo[0] && waited < 20) begin step1(); waited++; end
    chk("erase_reached", int'(bgo[0]), 1);
    move = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_erase_drawBG", int'(bgo[0]), 0);
    chk("rst_erase_busy", int'(byo[0]), 0);
    chk("rst_erase_x", int'(xo[0]), 95);
    chk("rst_erase_y", int'(yo[0]), 221);

    // Reset mid-draw restores the start position.
    start_run(2'd2, tA, 1'b0, 1'b0);
    waited = 0;
    while (!bgo[0] && waited < 20) begin step1(); waited++; end
    doneBG = 1'b1; move = 1'b0;
    waited = 0;
    while (!cho[0] && waited < 20) begin step1(); waited++; end
    doneBG = 1'b0;
    chk("draw_reached", int'(cho[0]), 1);
    chk("draw_x", int'(xo[0]), 96);
    #2 reset = 1'b1;
    #1;
    chk("rst_draw_drawChar", int'(cho[0]), 0);
    chk("rst_draw_x", int'(xo[0]), 95);
    chk("rst_draw_y", int'(yo[0]), 221);

    // Stalled erase across two ticks with move held: only one step.
    start_run(2'd2, tA, 1'b0, 1'b0);
    waited = 0;
    while (!bgo[0] && waited < 20) begin step1(); waited++; end
    repeat (10) step1();
    chk("stall_still_erasing", int'(bgo[0]), 1);
    doneBG = 1'b1;
    waited = 0;
    while (!cho[0] && waited < 20) begin step1(); waited++; end
    doneBG = 1'b0; move = 1'b0; doneChar = 1'b1;
    waited = 0;
    while (byo[0] && waited < 20) begin step1(); waited++; end
    doneChar = 1'b0;
    repeat (12) step1();
    chk("stall_busy_done", int'(byo[0]), 0);
    chk("stall_erase_count", bg_rises, 1);
    chk("stall_x", int'(xo[0]), 96);
    chk("stall_y", int'(yo[0]), 220);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
